// File: rtl/usb_hpi_master.sv
`default_nettype none
// ============================================================================
// Module   : usb_hpi_master
// Brief    : Host-port-interface bus master for the USB controller. It runs
//            programmable setup/strobe/hold timing and single-address bursts,
//            generates the controller reset pulse and latches interrupt flags.
// Revision : 1.0 - initial release
// ============================================================================
module usb_hpi_master #(
    parameter int DATA_W     = 16,
    parameter int ADDR_W     = 2,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 4,
    parameter int HOLD_CYC   = 1,
    parameter int RST_CYC    = 1024,
    parameter int LEN_W      = 8,
    parameter int N_INT      = 2
) (
    input  logic              clk_clk,
    input  logic              reset_reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy,
    input  logic [N_INT-1:0]  int_in,
    output logic [N_INT-1:0]  int_pend,
    input  logic [N_INT-1:0]  int_clr,
    input  logic [DATA_W-1:0] hpi_data_in,
    output logic [DATA_W-1:0] hpi_data_out,
    output logic              hpi_data_oe,
    output logic [ADDR_W-1:0] hpi_addr,
    output logic              hpi_cs_n,
    output logic              hpi_rd_n,
    output logic              hpi_wr_n,
    output logic              hpi_rst_n
);

    localparam logic [2:0] c_st_rst_hold = 3'd0;
    localparam logic [2:0] c_st_idle     = 3'd1;
    localparam logic [2:0] c_st_wdata    = 3'd2;
    localparam logic [2:0] c_st_setup    = 3'd3;
    localparam logic [2:0] c_st_strobe   = 3'd4;
    localparam logic [2:0] c_st_hold     = 3'd5;

    localparam int c_cnt_max0 = (RST_CYC > SETUP_CYC) ? RST_CYC : SETUP_CYC;
    localparam int c_cnt_max1 = (c_cnt_max0 > STROBE_CYC) ? c_cnt_max0 : STROBE_CYC;
    localparam int c_cnt_max  = (c_cnt_max1 > HOLD_CYC) ? c_cnt_max1 : HOLD_CYC;
    localparam int CNT_W      = $clog2(c_cnt_max + 1);

    localparam logic [CNT_W-1:0] c_rst_last    = CNT_W'(RST_CYC - 1);
    localparam logic [CNT_W-1:0] c_setup_last  = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] c_strobe_last = CNT_W'(STROBE_CYC - 1);
    localparam logic [CNT_W-1:0] c_hold_last   = CNT_W'(HOLD_CYC - 1);

    logic [2:0]        r_state;
    logic [2:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [LEN_W-1:0]  r_remaining;
    logic              r_write;
    logic              w_write_nxt;
    logic              w_cmd_hs;
    logic              w_wr_hs;
    logic              w_strobe_end;
    logic              w_hold_end;
    logic              w_bus_nxt;

    logic              r_cmd_ready;
    logic              r_wr_ready;
    logic              r_busy;
    logic              r_rd_valid;
    logic [DATA_W-1:0] r_rd_data;
    logic [DATA_W-1:0] r_hpi_data_out;
    logic              r_hpi_data_oe;
    logic [ADDR_W-1:0] r_hpi_addr;
    logic              r_hpi_cs_n;
    logic              r_hpi_rd_n;
    logic              r_hpi_wr_n;
    logic              r_hpi_rst_n;

    logic [N_INT-1:0]  r_int_s1;
    logic [N_INT-1:0]  r_int_s2;
    logic [N_INT-1:0]  r_int_s3;
    logic [N_INT-1:0]  r_int_pend;
    logic [N_INT-1:0]  w_int_rise;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_state <= c_st_rst_hold;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_write_nxt  = r_write;
        w_cmd_hs     = 1'b0;
        w_wr_hs      = 1'b0;
        w_strobe_end = 1'b0;
        w_hold_end   = 1'b0;
        case (r_state)
            c_st_rst_hold: begin
                if (r_cnt == c_rst_last) w_state_nxt = c_st_idle;
            end
            c_st_idle: begin
                if (cmd_valid) begin
                    w_cmd_hs    = 1'b1;
                    w_write_nxt = cmd_write;
                    w_state_nxt = cmd_write ? c_st_wdata : c_st_setup;
                end
            end
            c_st_wdata: begin
                if (wr_valid) begin
                    w_wr_hs     = 1'b1;
                    w_state_nxt = c_st_setup;
                end
            end
            c_st_setup: begin
                if (r_cnt == c_setup_last) w_state_nxt = c_st_strobe;
            end
            c_st_strobe: begin
                if (r_cnt == c_strobe_last) begin
                    w_strobe_end = 1'b1;
                    w_state_nxt  = c_st_hold;
                end
            end
            c_st_hold: begin
                if (r_cnt == c_hold_last) begin
                    w_hold_end = 1'b1;
                    if (r_remaining == '0) w_state_nxt = c_st_idle;
                    else                   w_state_nxt = r_write ? c_st_wdata : c_st_setup;
                end
            end
            default: w_state_nxt = c_st_rst_hold;
        endcase
        w_bus_nxt = (w_state_nxt == c_st_setup) || (w_state_nxt == c_st_strobe) ||
                    (w_state_nxt == c_st_hold);
    end

    // Outputs are registered from the next state so they line up with r_state.
    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_cnt          <= '0;
            r_remaining    <= '0;
            r_write        <= 1'b0;
            r_cmd_ready    <= 1'b0;
            r_wr_ready     <= 1'b0;
            r_busy         <= 1'b1;
            r_rd_valid     <= 1'b0;
            r_rd_data      <= '0;
            r_hpi_data_out <= '0;
            r_hpi_data_oe  <= 1'b0;
            r_hpi_addr     <= '0;
            r_hpi_cs_n     <= 1'b1;
            r_hpi_rd_n     <= 1'b1;
            r_hpi_wr_n     <= 1'b1;
            r_hpi_rst_n    <= 1'b0;
        end else begin
            if (w_state_nxt != r_state) r_cnt <= '0;
            else                        r_cnt <= r_cnt + CNT_W'(1);

            if (w_cmd_hs) begin
                r_remaining <= cmd_len;
                r_write     <= cmd_write;
                r_hpi_addr  <= cmd_addr;
            end else if (w_hold_end && (r_remaining != '0)) begin
                r_remaining <= r_remaining - LEN_W'(1);
            end

            if (w_wr_hs) r_hpi_data_out <= wr_data;

            r_rd_valid <= w_strobe_end && !r_write;
            if (w_strobe_end && !r_write) r_rd_data <= hpi_data_in;

            r_cmd_ready   <= (w_state_nxt == c_st_idle);
            r_wr_ready    <= (w_state_nxt == c_st_wdata);
            r_busy        <= (w_state_nxt != c_st_idle);
            r_hpi_rst_n   <= (w_state_nxt != c_st_rst_hold);
            r_hpi_cs_n    <= !w_bus_nxt;
            r_hpi_data_oe <= w_bus_nxt && w_write_nxt;
            r_hpi_rd_n    <= !((w_state_nxt == c_st_strobe) && !w_write_nxt);
            r_hpi_wr_n    <= !((w_state_nxt == c_st_strobe) && w_write_nxt);
        end
    end

    // Rising edges seen after the 2-flop synchroniser; set beats a same-cycle clear.
    assign w_int_rise = r_int_s2 & ~r_int_s3;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            r_int_s1   <= '0;
            r_int_s2   <= '0;
            r_int_s3   <= '0;
            r_int_pend <= '0;
        end else begin
            r_int_s1   <= int_in;
            r_int_s2   <= r_int_s1;
            r_int_s3   <= r_int_s2;
            r_int_pend <= (r_int_pend & ~int_clr) |
                          (w_int_rise & {N_INT{r_state != c_st_rst_hold}});
        end
    end

    assign cmd_ready    = r_cmd_ready;
    assign wr_ready     = r_wr_ready;
    assign busy         = r_busy;
    assign rd_valid     = r_rd_valid;
    assign rd_data      = r_rd_data;
    assign int_pend     = r_int_pend;
    assign hpi_data_out = r_hpi_data_out;
    assign hpi_data_oe  = r_hpi_data_oe;
    assign hpi_addr     = r_hpi_addr;
    assign hpi_cs_n     = r_hpi_cs_n;
    assign hpi_rd_n     = r_hpi_rd_n;
    assign hpi_wr_n     = r_hpi_wr_n;
    assign hpi_rst_n    = r_hpi_rst_n;

endmodule
`default_nettype wire

// File: tb/tb_usb_hpi_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_usb_hpi_master
// Brief    : Directed self-checking bench for usb_hpi_master (RST_CYC=16).
// Revision : 1.0 - initial release
// ============================================================================
module tb_usb_hpi_master;

    localparam int c_rst_cyc = 16;

    logic        clk_clk = 1'b0;
    logic        reset_reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_write = 1'b0;
    logic [1:0]  cmd_addr = '0;
    logic [7:0]  cmd_len = '0;
    logic        wr_valid = 1'b0;
    logic        wr_ready;
    logic [15:0] wr_data = '0;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        busy;
    logic [1:0]  int_in = '0;
    logic [1:0]  int_pend;
    logic [1:0]  int_clr = '0;
    logic [15:0] hpi_data_in = 16'hA000;
    logic [15:0] hpi_data_out;
    logic        hpi_data_oe;
    logic [1:0]  hpi_addr;
    logic        hpi_cs_n;
    logic        hpi_rd_n;
    logic        hpi_wr_n;
    logic        hpi_rst_n;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk_clk = ~clk_clk;

    usb_hpi_master #(.RST_CYC(c_rst_cyc)) u_dut (
        .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
        .int_in(int_in), .int_pend(int_pend), .int_clr(int_clr),
        .hpi_data_in(hpi_data_in), .hpi_data_out(hpi_data_out), .hpi_data_oe(hpi_data_oe),
        .hpi_addr(hpi_addr), .hpi_cs_n(hpi_cs_n), .hpi_rd_n(hpi_rd_n),
        .hpi_wr_n(hpi_wr_n), .hpi_rst_n(hpi_rst_n)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_clk);
    endtask

    // Called at a negedge with reset low; releases it and times the RST_HOLD phase.
    task automatic release_and_wait(input string tag);
        int k;
        int bad;
        k   = 0;
        bad = 0;
        reset_reset_n = 1'b1;
        while (hpi_rst_n !== 1'b1 && k < c_rst_cyc + 20) begin
            @(posedge clk_clk);
            #1;
            k++;
            if (hpi_rst_n !== 1'b1 &&
                (hpi_cs_n !== 1'b1 || hpi_rd_n !== 1'b1 || hpi_wr_n !== 1'b1 ||
                 rd_valid !== 1'b0 || hpi_data_oe !== 1'b0 || cmd_ready !== 1'b0))
                bad++;
        end
        check({tag, "_rst_len"}, k, c_rst_cyc);
        check({tag, "_quiet_in_rst"}, bad, 0);
        check({tag, "_cmd_ready"}, {31'b0, cmd_ready}, 1);
        check({tag, "_busy"}, {31'b0, busy}, 0);
    endtask

    initial begin
        int n_rd;
        int hs;
        step();
        check("rst_cs_n", {31'b0, hpi_cs_n}, 1);
        check("rst_rst_n", {31'b0, hpi_rst_n}, 0);
        check("rst_busy", {31'b0, busy}, 1);
        check("rst_cmd_ready", {31'b0, cmd_ready}, 0);
        check("rst_outs", {hpi_data_out, rd_data}, 0);
        check("rst_misc", {26'b0, rd_valid, wr_ready, hpi_data_oe, int_pend, hpi_rd_n}, 1);
        step();
        int_in[0] = 1'b1;    // edge lands while interrupts are masked
        release_and_wait("init");
        check("int0_masked", {30'b0, int_pend}, 0);

        // Single write, addr 2
        step();
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd2; cmd_len = 8'd0;
        wr_valid = 1'b1; wr_data = 16'h1234;
        step();
        cmd_valid = 1'b0;
        check("w1_wdata_ready", {30'b0, wr_ready, hpi_cs_n}, 3);
        step();
        wr_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            check("w1_cs_n", {31'b0, hpi_cs_n}, 0);
            check("w1_wr_n", {31'b0, hpi_wr_n}, (i >= 1 && i <= 4) ? 32'd0 : 32'd1);
            check("w1_bus", {13'b0, hpi_data_oe, hpi_addr, hpi_data_out}, {13'b0, 1'b1, 2'd2, 16'h1234});
            step();
        end
        check("w1_end", {29'b0, hpi_cs_n, cmd_ready, busy}, 3'b110);

        // Read burst of 4 at addr 0
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd0; cmd_len = 8'd3;
        hpi_data_in = 16'hA000;
        n_rd = 0;
        step();
        cmd_valid = 1'b0;
        for (int i = 1; i <= 24; i++) begin
            check("r4_cs_oe_addr", {28'b0, hpi_cs_n, hpi_data_oe, hpi_addr}, 0);
            check("r4_valid", {31'b0, rd_valid}, (i % 6 == 0) ? 32'd1 : 32'd0);
            if (rd_valid === 1'b1) begin
                check("r4_data", {16'b0, rd_data}, 32'hA000 + n_rd);
                n_rd++;
                hpi_data_in = 16'hA000 + 16'(n_rd);
            end
            step();
        end
        check("r4_count", n_rd, 4);
        check("r4_end", {30'b0, hpi_cs_n, cmd_ready}, 3);

        // Two-word write with a 5-cycle data gap
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 2'd1; cmd_len = 8'd1;
        wr_valid = 1'b1; wr_data = 16'h1111;
        step();
        cmd_valid = 1'b0;
        step();
        wr_valid = 1'b0;
        repeat (6) step();
        for (int i = 0; i < 5; i++) begin
            check("gap_cs_n", {29'b0, hpi_cs_n, busy, wr_ready}, 3'b111);
            step();
        end
        wr_valid = 1'b1; wr_data = 16'h2222;
        step();
        wr_valid = 1'b0;
        check("gap_w2_start", {15'b0, hpi_cs_n, hpi_data_oe, hpi_data_out}, {15'b0, 1'b0, 1'b1, 16'h2222});
        repeat (5) step();
        check("gap_hold_busy", {30'b0, busy, hpi_cs_n}, 2'b10);
        step();
        check("gap_done", {29'b0, busy, hpi_cs_n, cmd_ready}, 3'b011);

        // Maximum burst length must not wrap the word counter
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_len = 8'hFF;
        step();
        cmd_valid = 1'b0;
        n_rd = 0;
        hs = 0;
        while (cmd_ready !== 1'b1 && hs < 256 * 6 + 20) begin
            if (rd_valid === 1'b1) n_rd++;
            step();
            hs++;
        end
        check("max_words", n_rd, 256);
        check("max_cycles", hs, 256 * 6);

        // Interrupt latching
        int_in[1] = 1'b1;
        step();
        step();
        check("int_pre", {30'b0, int_pend}, 0);
        step();
        check("int_set", {30'b0, int_pend}, 2'b10);
        int_in[1] = 1'b0;
        repeat (3) step();
        int_in[1] = 1'b1;
        step();
        step();
        int_clr[1] = 1'b1;   // coincides with the new synchronised edge
        step();
        int_clr[1] = 1'b0;
        check("int_set_wins", {30'b0, int_pend}, 2'b10);
        repeat (2) step();
        int_clr[1] = 1'b1;
        step();
        int_clr[1] = 1'b0;
        check("int_cleared", {30'b0, int_pend}, 0);

        // Reset during the strobe of a read burst
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 2'd3; cmd_len = 8'd2;
        step();
        cmd_valid = 1'b0;
        step();
        step();
        check("mid_in_strobe", {30'b0, hpi_cs_n, hpi_rd_n}, 0);
        reset_reset_n = 1'b0;
        #1;
        check("mid_rst_bus", {28'b0, hpi_cs_n, hpi_rd_n, hpi_wr_n, hpi_rst_n}, 4'b1110);
        check("mid_rst_ctl", {28'b0, busy, cmd_ready, rd_valid, hpi_data_oe}, 4'b1000);
        check("mid_rst_addr", {30'b0, hpi_addr}, 0);
        step();
        step();
        release_and_wait("mid");
        check("mid_int_masked", {30'b0, int_pend}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout got=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
